regfile_alu_seq: RTL and testbench
==================================

Name: regfile_alu_seq

Overview:
- Parametrised successor to the 4x8-bit register/tmp/ALU datapath.
- Generalises the register file to WIDTH bits x NREGS entries and replaces the external lt/tsel/sr micro-control with an internal sequencer.
- One start strobe runs a full R[dst] = R[src_a] op R[src_b] operation with a busy/done handshake.
- Sits between the host loader (direct register writes) and the rest of the datapath, which reads R0 through out.

Parameters:
WIDTH, 8, datapath and register width in bits
NREGS, 4, number of registers (>=2); AW = max(1, clog2(NREGS)) is the index width

Ports:
clk     input   1      rising-edge clock
rst_n   input   1      asynchronous active-low reset
in      input   WIDTH  direct load data
ld      input   1      load strobe: R[ld_addr] <= in
ld_addr input   AW     load target index
start   input   1      begin operation; sampled only in IDLE
op      input   3      ALU operation, captured with start
dst     input   AW     destination index, captured with start
src_a   input   AW     operand A index, captured with start
src_b   input   AW     operand B index, captured with start
busy    output  1      high in FETCH, EXEC and WB
done    output  1      one-cycle pulse after writeback
result  output  WIDTH  last ALU result (registered)
zero    output  1      result == 0 (registered with result)
out     output  WIDTH  R0, continuous read of register 0

Behaviour:
- Reset (async, rst_n low):
  - All R[i] = 0; tmp = 0; result = 0; zero = 1.
  - State IDLE; busy = 0; done = 0; out = 0.
  - Reset mid-operation aborts the operation with no writeback.
- ALU (A = tmp, B = R[src_b]), all results truncated to WIDTH:
  - 000 A^B; 001 A&B; 010 A<<1 (LSB 0); 011 B; 100 A|B; 101 A+B mod 2^WIDTH; 110 A-B mod 2^WIDTH; 111 A>>1 logical.
- FSM states: IDLE, FETCH, EXEC, WB.
  - IDLE: if start at edge E0, latch op/dst/src_a/src_b and go to FETCH.
  - FETCH: tmp <= R[src_a]; go to EXEC.
  - EXEC: result <= alu(tmp, R[src_b]); zero updated; go to WB.
  - WB: R[dst] <= result; done <= 1; go to IDLE.
- Latency:
  - start sampled at E0; R[dst] is written at E3.
  - done is high for the single cycle between E3 and E4.
  - busy is high from after E0 until E3.
  - A new start may be sampled at E4, so back-to-back throughput is one operation per 4 cycles.
- start while busy: ignored, with no queueing.
- ld:
  - Accepted in any state except WB.
  - ld in IDLE together with start: the load commits at E0, so FETCH sees the loaded value.
  - ld during FETCH or EXEC to a source register: it commits, and the operation reads whatever value is present at the read edge.
  - ld in WB: dropped, so the writeback never conflicts with a load.
- Index out of range (NREGS not a power of 2): reads return 0; writes (ld or WB) are dropped.
- dst == src_a or dst == src_b: legal. Operands are read before WB, so the old values are used.
- out always reflects R0, including immediately after a ld or WB to index 0 (visible the cycle after the write edge).
- done is never asserted in the same cycle as busy.

Test Plan:
- Reset then idle: rst_n low mid-cycle -> out=0, busy=0, done=0, zero=1 immediately; all registers read 0 via later PASS ops.
- Load R1=0x3C, R2=0x0F; start op=000 dst=0 a=1 b=2 -> done at E3+; out=0x33, result=0x33, zero=0, busy high exactly 3 cycles.
- Wrap: R1=0xFF, R2=0x01, op=101 dst=3 -> R3=0x00, zero=1. Then op=110 a=3 b=2 -> 0xFF.
- Shifts: R1=0x81; op=010 dst=1 a=1 -> R1=0x02; op=111 dst=1 a=1 -> R1=0x01. In-place dst==src_a is correct.
- Hazards:
  - start asserted during busy -> ignored, one done only.
  - ld to R2=0x55 in WB cycle -> dropped, R2 unchanged.
  - ld+start in same IDLE cycle (R1<=0xAA, op=011 b=1 dst=0) -> out=0xAA.
- Reset during EXEC -> no done, dst unchanged (0); WIDTH=16, NREGS=6 build: op index 6/7 write dropped, read 0.

Source files
------------

// File: rtl/regfile_alu_seq.sv
// regfile_alu_seq: WIDTH x NREGS register file feeding a tmp/ALU datapath.
// An internal IDLE/FETCH/EXEC/WB sequencer runs one R[dst] = R[src_a] op R[src_b]
// per start strobe. Direct loads share the register file write port.
module regfile_alu_seq #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4,
  localparam int AW = (NREGS > 2) ? $clog2(NREGS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             ld,
  input  logic [AW-1:0]    ld_addr,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    dst,
  input  logic [AW-1:0]    src_a,
  input  logic [AW-1:0]    src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic [WIDTH-1:0] out
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, WB} state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_regs [NREGS];
  logic [WIDTH-1:0] r_tmp;
  logic [2:0]       r_op;
  logic [AW-1:0]    r_dst;
  logic [AW-1:0]    r_srcA;
  logic [AW-1:0]    r_srcB;
  logic [WIDTH-1:0] w_rdA;
  logic [WIDTH-1:0] w_rdB;
  logic [WIDTH-1:0] w_alu;
  logic             w_wbWe;
  logic             w_ldWe;

  assign busy   = (r_state != IDLE);
  assign out    = r_regs[0];
  assign w_wbWe = (r_state == WB);
  assign w_ldWe = ld && (r_state != WB);

  // State register; an async reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  // Next-state: a fixed walk through the three busy states, start only heard in IDLE.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (start) w_nextState = FETCH;
      FETCH:   w_nextState = EXEC;
      EXEC:    w_nextState = WB;
      WB:      w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Operand read ports; indices beyond the populated registers read as zero.
  always_comb begin
    w_rdA = '0;
    w_rdB = '0;
    if (int'(r_srcA) < NREGS) w_rdA = r_regs[r_srcA];
    if (int'(r_srcB) < NREGS) w_rdB = r_regs[r_srcB];
  end

  // ALU with A taken from tmp and B read live from the register file.
  always_comb begin
    w_alu = '0;
    case (r_op)
      3'b000: w_alu = r_tmp ^ w_rdB;
      3'b001: w_alu = r_tmp & w_rdB;
      3'b010: w_alu = {r_tmp[WIDTH-2:0], 1'b0};
      3'b011: w_alu = w_rdB;
      3'b100: w_alu = r_tmp | w_rdB;
      3'b101: w_alu = r_tmp + w_rdB;
      3'b110: w_alu = r_tmp - w_rdB;
      3'b111: w_alu = {1'b0, r_tmp[WIDTH-1:1]};
      default: w_alu = '0;
    endcase
  end

  // Datapath: capture the command, fetch A into tmp, register the result, pulse done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op   <= '0;
      r_dst  <= '0;
      r_srcA <= '0;
      r_srcB <= '0;
      r_tmp  <= '0;
      result <= '0;
      zero   <= 1'b1;
      done   <= 1'b0;
    end else begin
      done <= (r_state == WB);
      if (r_state == IDLE && start) begin
        r_op   <= op;
        r_dst  <= dst;
        r_srcA <= src_a;
        r_srcB <= src_b;
      end
      if (r_state == FETCH) r_tmp <= w_rdA;
      if (r_state == EXEC) begin
        result <= w_alu;
        zero   <= (w_alu == '0);
      end
    end
  end

  // Register file write port: writeback owns the WB cycle, loads are taken otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (w_wbWe && r_dst == AW'(i))        r_regs[i] <= result;
        else if (w_ldWe && ld_addr == AW'(i)) r_regs[i] <= in;
      end
    end
  end

endmodule

// File: tb/tb_regfile_alu_seq.sv
// Testbench for regfile_alu_seq: table of directed operations on the default 8x4
// build, hand sequences for handshake hazards, and a 16x6 build for out-of-range indices.
module tb_regfile_alu_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  logic [7:0]  in = '0;
  logic        ld = 1'b0;
  logic [1:0]  ld_addr = '0;
  logic        start = 1'b0;
  logic [2:0]  op = '0;
  logic [1:0]  dst = '0;
  logic [1:0]  src_a = '0;
  logic [1:0]  src_b = '0;
  logic        busy;
  logic        done;
  logic [7:0]  result;
  logic        zero;
  logic [7:0]  out;

  logic [15:0] wIn = '0;
  logic        wLd = 1'b0;
  logic [2:0]  wLdAddr = '0;
  logic        wStart = 1'b0;
  logic [2:0]  wOp = '0;
  logic [2:0]  wDst = '0;
  logic [2:0]  wSrcA = '0;
  logic [2:0]  wSrcB = '0;
  logic        wBusy;
  logic        wDone;
  logic [15:0] wResult;
  logic        wZero;
  logic [15:0] wOut;

  int checks = 0;
  int errors = 0;

  regfile_alu_seq #(.WIDTH(8), .NREGS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in(in), .ld(ld), .ld_addr(ld_addr),
    .start(start), .op(op), .dst(dst), .src_a(src_a), .src_b(src_b),
    .busy(busy), .done(done), .result(result), .zero(zero), .out(out)
  );

  regfile_alu_seq #(.WIDTH(16), .NREGS(6)) dutWide (
    .clk(clk), .rst_n(rst_n), .in(wIn), .ld(wLd), .ld_addr(wLdAddr),
    .start(wStart), .op(wOp), .dst(wDst), .src_a(wSrcA), .src_b(wSrcB),
    .busy(wBusy), .done(wDone), .result(wResult), .zero(wZero), .out(wOut)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  typedef struct {
    bit         lEn;
    logic [1:0] lAddr;
    logic [7:0] lVal;
    bit         mEn;
    logic [1:0] mAddr;
    logic [7:0] mVal;
    logic [2:0] vOp;
    logic [1:0] vDst;
    logic [1:0] vA;
    logic [1:0] vB;
    logic [7:0] expRes;
    bit         expZero;
    logic [7:0] expOut;
  } vec_t;

  vec_t vecs [15];

  // Single comparison with failure reporting.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Direct register load through the ld port on the chosen build.
  task automatic loadReg(input bit wide, input logic [2:0] addr, input logic [15:0] val);
    @(negedge clk);
    if (wide) begin wLd = 1'b1; wLdAddr = addr; wIn = val; end
    else begin ld = 1'b1; ld_addr = addr[1:0]; in = val[7:0]; end
    @(negedge clk);
    wLd = 1'b0;
    ld  = 1'b0;
  endtask

  // Called at the negedge after E0: checks busy for three cycles then a one-cycle done.
  task automatic waitDone(input bit wide, input string tag);
    int  busyCycles;
    bit  gotDone;
    busyCycles = 0;
    gotDone    = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (wide ? wDone : done) begin
        gotDone = 1'b1;
        break;
      end
      if (wide ? wBusy : busy) busyCycles++;
      @(negedge clk);
    end
    checkOutput({tag, ".doneSeen"}, 32'(gotDone), 32'd1);
    checkOutput({tag, ".busyCycles"}, busyCycles, 32'd3);
    checkOutput({tag, ".busyWithDone"}, 32'(wide ? wBusy : busy), 32'd0);
    @(negedge clk);
    checkOutput({tag, ".donePulse"}, 32'(wide ? wDone : done), 32'd0);
  endtask

  // Issue one operation with a single-cycle start strobe and wait for it to finish.
  task automatic applyStimulus(input bit wide, input logic [2:0] o, input logic [2:0] d,
                               input logic [2:0] a, input logic [2:0] b, input string tag);
    @(negedge clk);
    if (wide) begin wOp = o; wDst = d; wSrcA = a; wSrcB = b; wStart = 1'b1; end
    else begin op = o; dst = d[1:0]; src_a = a[1:0]; src_b = b[1:0]; start = 1'b1; end
    @(negedge clk);
    start  = 1'b0;
    wStart = 1'b0;
    waitDone(wide, tag);
  endtask

  initial begin
    int doneCount;

    vecs[0]  = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 3'b011, 2'd0, 2'd0, 2'd1, 8'h00, 1'b1, 8'h00};
    vecs[1]  = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 3'b011, 2'd0, 2'd0, 2'd2, 8'h00, 1'b1, 8'h00};
    vecs[2]  = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 3'b011, 2'd0, 2'd0, 2'd3, 8'h00, 1'b1, 8'h00};
    vecs[3]  = '{1'b1, 2'd1, 8'h3C, 1'b1, 2'd2, 8'h0F, 3'b000, 2'd0, 2'd1, 2'd2, 8'h33, 1'b0, 8'h33};
    vecs[4]  = '{1'b1, 2'd1, 8'hFF, 1'b1, 2'd2, 8'h01, 3'b101, 2'd3, 2'd1, 2'd2, 8'h00, 1'b1, 8'h33};
    vecs[5]  = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 3'b110, 2'd0, 2'd3, 2'd2, 8'hFF, 1'b0, 8'hFF};
    vecs[6]  = '{1'b1, 2'd1, 8'h81, 1'b0, 2'd0, 8'h00, 3'b010, 2'd1, 2'd1, 2'd0, 8'h02, 1'b0, 8'hFF};
    vecs[7]  = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 3'b111, 2'd1, 2'd1, 2'd0, 8'h01, 1'b0, 8'hFF};
    vecs[8]  = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 3'b011, 2'd0, 2'd0, 2'd1, 8'h01, 1'b0, 8'h01};
    vecs[9]  = '{1'b1, 2'd2, 8'hF0, 1'b1, 2'd3, 8'h3C, 3'b001, 2'd0, 2'd2, 2'd3, 8'h30, 1'b0, 8'h30};
    vecs[10] = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 3'b100, 2'd2, 2'd0, 2'd1, 8'h31, 1'b0, 8'h30};
    vecs[11] = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 3'b011, 2'd0, 2'd0, 2'd2, 8'h31, 1'b0, 8'h31};
    vecs[12] = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 3'b101, 2'd2, 2'd2, 2'd2, 8'h62, 1'b0, 8'h31};
    vecs[13] = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 3'b110, 2'd0, 2'd2, 2'd0, 8'h31, 1'b0, 8'h31};
    vecs[14] = '{1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 3'b000, 2'd0, 2'd0, 2'd0, 8'h00, 1'b1, 8'h00};

    // Asynchronous reset asserted mid-cycle must clear the outputs at once.
    #3 rst_n = 1'b0;
    #1;
    checkOutput("rst.out", out, 32'h00);
    checkOutput("rst.busy", busy, 32'd0);
    checkOutput("rst.done", done, 32'd0);
    checkOutput("rst.zero", zero, 32'd1);
    checkOutput("rst.result", result, 32'h00);
    checkOutput("rst.wideZero", wZero, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Table of directed operations.
    for (int i = 0; i < 15; i++) begin
      if (vecs[i].lEn) loadReg(1'b0, {1'b0, vecs[i].lAddr}, {8'h00, vecs[i].lVal});
      if (vecs[i].mEn) loadReg(1'b0, {1'b0, vecs[i].mAddr}, {8'h00, vecs[i].mVal});
      applyStimulus(1'b0, vecs[i].vOp, {1'b0, vecs[i].vDst}, {1'b0, vecs[i].vA},
                    {1'b0, vecs[i].vB}, $sformatf("vec%0d", i));
      checkOutput($sformatf("vec%0d.result", i), result, vecs[i].expRes);
      checkOutput($sformatf("vec%0d.zero", i), zero, vecs[i].expZero);
      checkOutput($sformatf("vec%0d.out", i), out, vecs[i].expOut);
    end
    // Registers now: R0=00 R1=01 R2=62 R3=3C.

    // start held high while busy (with a different operand) must be ignored.
    @(negedge clk);
    op = 3'b011; dst = 2'd0; src_a = 2'd0; src_b = 2'd1; start = 1'b1;
    @(negedge clk);
    src_b = 2'd2;
    doneCount = 0;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (done) doneCount++;
    end
    checkOutput("busyStart.doneCount", doneCount, 32'd1);
    checkOutput("busyStart.out", out, 32'h01);

    // ld in the WB cycle is dropped.
    @(negedge clk);
    op = 3'b011; dst = 2'd3; src_a = 2'd0; src_b = 2'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    ld = 1'b1; ld_addr = 2'd2; in = 8'h55;
    @(negedge clk);
    ld = 1'b0;
    checkOutput("wbLoad.done", done, 32'd1);
    applyStimulus(1'b0, 3'b011, 3'd0, 3'd0, 3'd2, "wbLoadR2");
    checkOutput("wbLoad.r2", out, 32'h62);
    applyStimulus(1'b0, 3'b011, 3'd0, 3'd0, 3'd3, "wbLoadR3");
    checkOutput("wbLoad.r3", out, 32'h01);

    // ld together with start in IDLE: the operation sees the loaded value.
    @(negedge clk);
    ld = 1'b1; ld_addr = 2'd1; in = 8'hAA;
    op = 3'b011; dst = 2'd0; src_a = 2'd0; src_b = 2'd1; start = 1'b1;
    @(negedge clk);
    ld = 1'b0; start = 1'b0;
    waitDone(1'b0, "ldStart");
    checkOutput("ldStart.out", out, 32'hAA);

    // ld to a source register during FETCH commits before the operand read.
    @(negedge clk);
    op = 3'b011; dst = 2'd0; src_a = 2'd0; src_b = 2'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ld = 1'b1; ld_addr = 2'd1; in = 8'h77;
    waitDone(1'b0, "ldFetch");
    ld = 1'b0;
    checkOutput("ldFetch.out", out, 32'h77);

    // Reset during EXEC aborts with no done and no writeback.
    @(negedge clk);
    op = 3'b011; dst = 2'd0; src_a = 2'd0; src_b = 2'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("execRst.busy", busy, 32'd0);
    checkOutput("execRst.out", out, 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    doneCount = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) doneCount++;
    end
    checkOutput("execRst.doneCount", doneCount, 32'd0);
    checkOutput("execRst.outAfter", out, 32'h00);
    checkOutput("execRst.zero", zero, 32'd1);

    // Wide build with six registers: indices 6 and 7 are out of range.
    loadReg(1'b1, 3'd6, 16'h1234);
    loadReg(1'b1, 3'd5, 16'hABCD);
    applyStimulus(1'b1, 3'b011, 3'd0, 3'd0, 3'd6, "wideRd6");
    checkOutput("wideRd6.result", wResult, 32'h0000);
    checkOutput("wideRd6.zero", wZero, 32'd1);
    applyStimulus(1'b1, 3'b011, 3'd7, 3'd0, 3'd5, "wideWr7");
    checkOutput("wideWr7.result", wResult, 32'hABCD);
    checkOutput("wideWr7.out", wOut, 32'h0000);
    applyStimulus(1'b1, 3'b011, 3'd0, 3'd0, 3'd7, "wideRd7");
    checkOutput("wideRd7.result", wResult, 32'h0000);
    applyStimulus(1'b1, 3'b101, 3'd0, 3'd5, 3'd5, "wideAdd");
    checkOutput("wideAdd.result", wResult, 32'h579A);
    checkOutput("wideAdd.out", wOut, 32'h579A);
    checkOutput("wideAdd.zero", wZero, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
